// File: rtl/qspi_reg_axi_master.sv
// qspi_reg_axi_master
// Bridges a byte-wide register command stream onto single-beat AXI4
// transactions. Each command moves one byte at a byte address. The byte is
// steered onto its lane of the DW-bit bus and one response is returned per
// command. Only one transaction is in flight at a time.
//
// Ports
//   aclk, aresetn          clock and asynchronous active-low reset
//   cmd_*                  command in: valid/ready, write flag, byte address, write byte
//   rsp_*                  response out: valid/ready, read byte (0 for writes), error flag
//   m_aw*, m_w*, m_b*      AXI write address, write data and write response channels
//   m_ar*, m_r*            AXI read address and read data channels
module qspi_reg_axi_master #(
  parameter int IDW = 8,
  parameter int DW = 128,
  parameter int AW = 32,
  parameter logic [IDW-1:0] AXI_ID = 8'd24
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [7:0]      cmd_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [7:0]      rsp_rdata,
  output logic            rsp_err,
  output logic [IDW-1:0]  m_awid,
  output logic [AW-1:0]   m_awaddr,
  output logic [7:0]      m_awlen,
  output logic [2:0]      m_awsize,
  output logic [1:0]      m_awburst,
  output logic            m_awlock,
  output logic [2:0]      m_awcache,
  output logic            m_awvalid,
  input  logic            m_awready,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wstrb,
  output logic            m_wlast,
  output logic            m_wvalid,
  input  logic            m_wready,
  input  logic [IDW-1:0]  m_bid,
  input  logic [1:0]      m_bresp,
  input  logic            m_bvalid,
  output logic            m_bready,
  output logic [IDW-1:0]  m_arid,
  output logic [AW-1:0]   m_araddr,
  output logic [7:0]      m_arlen,
  output logic [2:0]      m_arsize,
  output logic [1:0]      m_arburst,
  output logic            m_arvalid,
  input  logic            m_arready,
  input  logic [IDW-1:0]  m_rid,
  input  logic [DW-1:0]   m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic            m_rlast,
  input  logic            m_rvalid,
  output logic            m_rready
);

  localparam int NB = DW / 8;
  // Keep the lane register at least one bit wide so an 8-bit bus still elaborates.
  localparam int LW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {IDLE, WREQ, WRESP, RREQ, RDATA, RSP} state_t;

  state_t        state;
  logic [LW-1:0] lane;
  logic [LW-1:0] cmd_lane;

  // Only bit 1 of a response (SLVERR/DECERR) signals an error; bit 0 is don't-care.
  logic unused_resp_lsb;
  assign unused_resp_lsb = ^{m_bresp[0], m_rresp[0]};

  // Modulo rather than a slice so the lane index is 0 for a single-lane bus.
  assign cmd_lane = LW'(cmd_addr % AW'(NB));

  // Single beat, single byte, incrementing burst type, fixed ID.
  assign m_awid    = AXI_ID;
  assign m_awlen   = 8'd0;
  assign m_awsize  = 3'b000;
  assign m_awburst = 2'b01;
  assign m_awlock  = 1'b0;
  assign m_awcache = 3'b000;
  assign m_wlast   = 1'b1;
  assign m_arid    = AXI_ID;
  assign m_arlen   = 8'd0;
  assign m_arsize  = 3'b000;
  assign m_arburst = 2'b01;

  // Depends on state only, so a source may wait for ready before raising valid.
  assign cmd_ready = (state == IDLE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      lane      <= '0;
      m_awaddr  <= '0;
      m_awvalid <= 1'b0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_araddr  <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            lane <= cmd_lane;
            if (cmd_write) begin
              m_awaddr  <= cmd_addr;
              m_wdata   <= DW'(cmd_wdata) << (8 * cmd_lane);
              m_wstrb   <= NB'(1) << cmd_lane;
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              state     <= WREQ;
            end else begin
              m_araddr  <= cmd_addr;
              m_arvalid <= 1'b1;
              state     <= RREQ;
            end
          end
        end
        WREQ: begin
          // AW and W retire independently; a dropped valid marks its channel done.
          if (m_awvalid && m_awready) m_awvalid <= 1'b0;
          if (m_wvalid && m_wready) m_wvalid <= 1'b0;
          if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
            m_bready <= 1'b1;
            state    <= WRESP;
          end
        end
        WRESP: begin
          if (m_bvalid) begin
            m_bready  <= 1'b0;
            rsp_rdata <= 8'd0;
            rsp_err   <= m_bresp[1] | (m_bid != AXI_ID);
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        RREQ: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= RDATA;
          end
        end
        RDATA: begin
          if (m_rvalid) begin
            m_rready  <= 1'b0;
            rsp_rdata <= m_rdata[8*lane +: 8];
            rsp_err   <= m_rresp[1] | (m_rid != AXI_ID) | !m_rlast;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/qspi_reg_axi_master.md
# qspi_reg_axi_master

Upstream command-to-AXI bridge for the `spi_axi_if` QSPI controller. It converts a simple byte-wide register command stream (write/read one byte at a byte address) into single-beat AXI4 transactions on the controller's slave port. It performs byte-lane steering onto the 128-bit data bus and returns one response per command. One transaction is outstanding at a time.

## Interface
- IDW, 8, AXI ID width
- DW, 128, AXI data width; must be a power of two, 8 or greater
- AW, 32, address width
- AXI_ID, 8'd24, constant ID driven on awid/arid and expected on bid/rid
- aclk  in  1  clock; all logic on the rising edge
- aresetn  in  1  reset; asynchronous, active-low
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  AW  byte address
- cmd_wdata  in  8  write byte
- rsp_valid / rsp_ready  out/in  1  response handshake
- rsp_rdata  out  8  read byte; 0 for writes
- rsp_err  out  1  error flag for the completed command
- m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awvalid / m_awready: AXI AW channel (IDW, AW, 8, 3, 2, 1, 3, 1/1)
- m_wdata, m_wstrb, m_wlast, m_wvalid / m_wready: AXI W channel (DW, DW/8, 1, 1/1)
- m_bid, m_bresp, m_bvalid / m_bready: AXI B channel (IDW, 2, 1/1)
- m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid / m_arready: AXI AR channel
- m_rid, m_rdata, m_rresp, m_rlast, m_rvalid / m_rready: AXI R channel

## Operation
- Lane index L = cmd_addr[log2(DW/8)-1:0].
- Constant fields: awlen = arlen = 0, awsize = arsize = 3'b000, awburst = arburst = 2'b01, awlock = 0, awcache = 0, wlast = 1, awid = arid = AXI_ID.
- Write data: m_wdata = cmd_wdata << (8*L), other lanes 0. m_wstrb = 1 << L. m_awaddr = cmd_addr, passed through unaligned.
- Read data: rsp_rdata = m_rdata[8*L +: 8].
- FSM states: IDLE, WREQ, WRESP, RREQ, RDATA, RSP.
  - IDLE: cmd_ready = 1. When cmd_valid is high, capture the command and go to WREQ (write) or RREQ (read).
  - WREQ: assert m_awvalid and m_wvalid together. Each channel drops independently after its own handshake, and the held data stays stable until it is accepted. When both channels are done, go to WRESP. AW and W may complete in either order or in the same cycle.
  - WRESP: m_bready = 1. On bvalid, set err = bresp[1] OR (bid != AXI_ID), then go to RSP.
  - RREQ: m_arvalid = 1 until arready, then go to RDATA.
  - RDATA: m_rready = 1. On rvalid, capture the lane byte and set err = rresp[1] OR (rid != AXI_ID) OR !rlast, then go to RSP.
  - RSP: rsp_valid = 1 and held with stable data until rsp_ready, then go to IDLE.
- The block never drives two request channels of different types at once and never issues a new command before its response is accepted.
- Unsolicited bvalid/rvalid outside WRESP/RDATA are ignored, since bready/rready are low.

## Timing
- Reset values: all *valid, *ready, rsp_err = 0; rsp_rdata, m_wdata, m_wstrb, addresses = 0; state = IDLE.
- Asynchronous reset mid-transaction: outputs return to reset values immediately. The in-flight command is dropped with no response.
- cmd_ready is combinational from state only, with no dependence on cmd_valid.
- All AXI outputs and rsp_* are registered.
- Zero-wait slave, write: command accepted at cycle 0; aw/w valid at cycle 1; B handshake at cycle 2 if bvalid is returned at cycle 2; rsp_valid at cycle 3.
- Zero-wait slave, read: arvalid at cycle 1; R handshake at cycle 2; rsp_valid at cycle 3.
- Once asserted, a valid stays asserted until its handshake completes (AXI rule). Address, data and strobe do not change while valid is high.
- rsp_ready held low keeps the block in RSP. cmd_ready stays 0 throughout.

## Test plan
- Write addr 32'h1fff030F, data 8'h80, zero-wait slave → awaddr 32'h1fff030F, wstrb 16'h8000, wdata[127:120] = 8'h80 with other bits 0, rsp_valid at cycle 3, rsp_err = 0.
- Write 32'h1fff0303, data 8'h01, with awready delayed 3 cycles and wready immediate → wvalid drops after 1 cycle, awvalid held 4 cycles, wstrb 16'h0008, one B handshake, rsp_err = 0.
- Read 32'h1fff0302, slave returns rdata[23:16] = 8'h5A, rresp = 0, rlast = 1 → araddr 32'h1fff0302, rsp_rdata = 8'h5A, rsp_err = 0.
- Error paths: write with bresp = 2'b10 → rsp_err = 1; read with rid = 8'd25 → rsp_err = 1; read with rlast = 0 → rsp_err = 1.
- Back-to-back commands with rsp_ready low for 5 cycles → rsp_valid and rsp_rdata stable, cmd_ready = 0 and no AXI valids until the response is accepted; the second command then starts the cycle after acceptance.
- Deassert aresetn while in WREQ with awvalid high → awvalid/wvalid fall within the same cycle; after release, state is IDLE with cmd_ready = 1 and no stale response.
